// File: rtl/register_file_multibank_pkg.sv
// Shared constants, state encoding and width helpers for the multibank register file.
package register_file_multibank_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32'd32;
  localparam int unsigned NREGS_DEFAULT = 32'd32;

  // Architectural bank numbering.
  localparam int unsigned BANK_INT = 32'd0;
  localparam int unsigned BANK_FP  = 32'd1;

  // Controller states: CLEAR zeroes every bank after reset, IDLE serves accesses.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_e;

  // Index width for a bank of nregs entries (nregs is a power of two, >= 2).
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 32'd1) ? unsigned'($clog2(nregs)) : 32'd1;
  endfunction

  // Bank-select width; at least one bit even with a single bank.
  function automatic int unsigned bank_width(input int unsigned nbanks);
    return (nbanks > 32'd1) ? unsigned'($clog2(nbanks)) : 32'd1;
  endfunction

endpackage

// File: rtl/register_file_multibank_if.sv
// Decode/writeback-side bus of the multibank register file.
interface register_file_multibank_if #(
  parameter int unsigned XLEN = 32'd32,
  parameter int unsigned AW   = 32'd5,
  parameter int unsigned BW   = 32'd1
);
  logic            ready;
  logic            rd_en;
  logic [AW-1:0]   rs1_addr;
  logic [BW-1:0]   rs1_bank;
  logic [AW-1:0]   rs2_addr;
  logic [BW-1:0]   rs2_bank;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rd_valid;
  logic            we;
  logic [AW-1:0]   wd_addr;
  logic [BW-1:0]   wd_bank;
  logic [XLEN-1:0] wd_data;

  // Core side: issues reads and writes.
  modport master (
    input  ready, rs1_data, rs2_data, rd_valid,
    output rd_en, rs1_addr, rs1_bank, rs2_addr, rs2_bank,
           we, wd_addr, wd_bank, wd_data
  );

  // Register file side.
  modport slave (
    output ready, rs1_data, rs2_data, rd_valid,
    input  rd_en, rs1_addr, rs1_bank, rs2_addr, rs2_bank,
           we, wd_addr, wd_bank, wd_data
  );
endinterface

// File: rtl/register_file_multibank_register_bank.sv
// One register bank: one write port, two combinational-address read ports, no reset on storage.
module register_bank #(
  parameter int unsigned XLEN  = 32'd32,
  parameter int unsigned NREGS = 32'd32,
  parameter int unsigned AW    = 32'd5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem_q [NREGS];

  // Storage update; contents are defined only by the controller's clear sequence.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/register_file_multibank.sv
// Multibank register file: clear FSM, bank muxing, hardwired-zero masking, bypass, registered reads.
module register_file_multibank
  import register_file_multibank_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned NREGS     = NREGS_DEFAULT,
  parameter int unsigned NBANKS    = 32'd2,
  parameter logic [31:0] ZERO_MASK = 32'd1,
  parameter bit          BYPASS    = 1'b1
) (
  input logic CLK,
  input logic RESET,
  register_file_multibank_if.slave bus
);

  localparam int unsigned AW = addr_width(NREGS);
  localparam int unsigned BW = bank_width(NBANKS);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic            rd_valid_q, rd_valid_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;

  logic              wr_ok_s;
  logic [NBANKS-1:0] bank_we_s;
  logic [AW-1:0]     bank_waddr_s;
  logic [XLEN-1:0]   bank_wdata_s;
  logic [XLEN-1:0]   bank_rd1_s [NBANKS];
  logic [XLEN-1:0]   bank_rd2_s [NBANKS];
  logic [XLEN-1:0]   raw1_s, raw2_s;

  // A bank select beyond NBANKS addresses nothing.
  function automatic logic bank_in_range(input logic [BW-1:0] bank);
    return (32'(bank) < NBANKS);
  endfunction

  // Entry 0 of a bank whose ZERO_MASK bit is set is hardwired to zero.
  function automatic logic is_hw_zero(input logic [BW-1:0] bank, input logic [AW-1:0] addr);
    logic hz;
    hz = 1'b0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      hz = hz | ((ZERO_MASK[b] == 1'b1) && (bank == BW'(b)) && (addr == {AW{1'b0}}));
    end
    return hz;
  endfunction

  // Final value of one read port: range/zero masking first, then same-cycle forwarding.
  function automatic logic [XLEN-1:0] resolve_read(
    input logic [BW-1:0]   bank,
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] raw,
    input logic            wr_ok,
    input logic [BW-1:0]   w_bank,
    input logic [AW-1:0]   w_addr,
    input logic [XLEN-1:0] w_data
  );
    logic [XLEN-1:0] v;
    if (!bank_in_range(bank) || is_hw_zero(bank, addr)) begin
      v = {XLEN{1'b0}};
    end else if ((BYPASS == 1'b1) && wr_ok && (w_bank == bank) && (w_addr == addr)) begin
      v = w_data;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  assign wr_ok_s = (state_q == IDLE) && !RESET && bus.we &&
                   bank_in_range(bus.wd_bank) && !is_hw_zero(bus.wd_bank, bus.wd_addr);

  // Bank write steering: the clear sequence zeroes every bank, otherwise only the selected one.
  always_comb begin
    bank_we_s    = {NBANKS{1'b0}};
    bank_waddr_s = bus.wd_addr;
    bank_wdata_s = bus.wd_data;
    if (state_q == CLEAR) begin
      bank_we_s    = {NBANKS{1'b1}};
      bank_waddr_s = clr_idx_q;
      bank_wdata_s = {XLEN{1'b0}};
    end else begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
        bank_we_s[b] = wr_ok_s && (bus.wd_bank == BW'(b));
      end
    end
  end

  for (genvar gb = 0; gb < NBANKS; gb++) begin : gen_banks
    register_bank #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_bank (
      .clk    (CLK),
      .we     (bank_we_s[gb]),
      .waddr  (bank_waddr_s),
      .wdata  (bank_wdata_s),
      .raddr1 (bus.rs1_addr),
      .raddr2 (bus.rs2_addr),
      .rdata1 (bank_rd1_s[gb]),
      .rdata2 (bank_rd2_s[gb])
    );
  end

  // Select the addressed bank's raw read data for each port.
  always_comb begin
    raw1_s = {XLEN{1'b0}};
    raw2_s = {XLEN{1'b0}};
    for (int unsigned b = 0; b < NBANKS; b++) begin
      raw1_s = (bus.rs1_bank == BW'(b)) ? bank_rd1_s[b] : raw1_s;
      raw2_s = (bus.rs2_bank == BW'(b)) ? bank_rd2_s[b] : raw2_s;
    end
  end

  // Next-state logic for the clear/idle controller and the registered read outputs.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ready_d    = ready_q;
    rd_valid_d = 1'b0;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1'b1);
        if (clr_idx_q == AW'(NREGS - 32'd1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        if (bus.rd_en) begin
          rd_valid_d = 1'b1;
          rs1_data_d = resolve_read(bus.rs1_bank, bus.rs1_addr, raw1_s,
                                    wr_ok_s, bus.wd_bank, bus.wd_addr, bus.wd_data);
          rs2_data_d = resolve_read(bus.rs2_bank, bus.rs2_addr, raw2_s,
                                    wr_ok_s, bus.wd_bank, bus.wd_addr, bus.wd_data);
        end else begin
          rd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = {AW{1'b0}};
        ready_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that restarts the clear sequence.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= CLEAR;
      clr_idx_q  <= {AW{1'b0}};
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rs1_data_q <= {XLEN{1'b0}};
      rs2_data_q <= {XLEN{1'b0}};
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rs1_data = rs1_data_q;
  assign bus.rs2_data = rs2_data_q;

endmodule

// File: tb/tb_register_file_multibank.sv
// Bench for register_file_multibank: three configurations driven with identical stimulus,
// each checked against a behavioural model plus a directed vector table.
module tb_register_file_multibank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_file_multibank_if #(.XLEN(32), .AW(5), .BW(1)) if_a ();
  register_file_multibank_if #(.XLEN(32), .AW(5), .BW(1)) if_b ();
  register_file_multibank_if #(.XLEN(32), .AW(5), .BW(2)) if_c ();

  register_file_multibank #(.XLEN(32), .NREGS(32), .NBANKS(2), .ZERO_MASK(32'd1), .BYPASS(1'b1))
    u_a (.CLK(clk), .RESET(rst), .bus(if_a.slave));
  register_file_multibank #(.XLEN(32), .NREGS(32), .NBANKS(2), .ZERO_MASK(32'd1), .BYPASS(1'b0))
    u_b (.CLK(clk), .RESET(rst), .bus(if_b.slave));
  register_file_multibank #(.XLEN(32), .NREGS(32), .NBANKS(3), .ZERO_MASK(32'd1), .BYPASS(1'b1))
    u_c (.CLK(clk), .RESET(rst), .bus(if_c.slave));

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  wb;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [1:0]  b1;
    logic [4:0]  a1;
    logic [1:0]  b2;
    logic [4:0]  a2;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        ev;
    logic [31:0] e1 [3];
    logic [31:0] e2 [3];
  } vec_t;

  // Per-configuration properties: bank count, bypass, usable bank-select bits.
  int unsigned nb    [3] = '{2, 2, 3};
  bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
  logic [1:0]  bmask [3] = '{2'b01, 2'b01, 2'b11};

  // Reference model state.
  logic [31:0] mem_m [3][4][32];
  logic [31:0] out1_m [3];
  logic [31:0] out2_m [3];
  logic        valid_m;
  logic        ready_m;
  int          clr_m;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic we, input logic [1:0] wb, input logic [4:0] wa,
                               input logic [31:0] wd, input logic re,
                               input logic [1:0] b1, input logic [4:0] a1,
                               input logic [1:0] b2, input logic [4:0] a2);
    stim_t s;
    s.rst = 1'b0; s.we = we; s.wb = wb; s.wa = wa; s.wd = wd;
    s.re = re; s.b1 = b1; s.a1 = a1; s.b2 = b2; s.a2 = a2;
    return s;
  endfunction

  function automatic stim_t idle_s();
    return mk(1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0);
  endfunction

  function automatic stim_t rst_s();
    stim_t s;
    s = idle_s();
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic add_vec(input stim_t s, input logic ev,
                         input logic [31:0] e1a, input logic [31:0] e1b, input logic [31:0] e1c,
                         input logic [31:0] e2a, input logic [31:0] e2b, input logic [31:0] e2c);
    vec_t v;
    v.s = s; v.ev = ev;
    v.e1[0] = e1a; v.e1[1] = e1b; v.e1[2] = e1c;
    v.e2[0] = e2a; v.e2[1] = e2b; v.e2[2] = e2c;
    tbl.push_back(v);
  endtask

  // Value a read port should return, from the architectural rules.
  function automatic logic [31:0] mdl_read(input int k, input logic [1:0] b, input logic [4:0] a,
                                           input stim_t s, input logic wvalid, input logic [1:0] wbe);
    logic [1:0] be;
    be = b & bmask[k];
    if (32'(be) >= nb[k]) return 32'd0;
    if (be == 2'd0 && a == 5'd0) return 32'd0;
    if (byp[k] && wvalid && be == wbe && a == s.wa) return s.wd;
    return mem_m[k][be][a];
  endfunction

  // Advance the model by one clock edge.
  task automatic model_edge(input stim_t s);
    logic [1:0] wbe;
    logic       wvalid;
    if (s.rst) begin
      ready_m = 1'b0; clr_m = 0; valid_m = 1'b0;
      for (int k = 0; k < 3; k++) begin out1_m[k] = 32'd0; out2_m[k] = 32'd0; end
    end else if (!ready_m) begin
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 4; b++) mem_m[k][b][clr_m] = 32'd0;
      clr_m++;
      valid_m = 1'b0;
      if (clr_m == 32) ready_m = 1'b1;
    end else begin
      valid_m = s.re;
      for (int k = 0; k < 3; k++) begin
        wbe    = s.wb & bmask[k];
        wvalid = s.we && (32'(wbe) < nb[k]) && !(wbe == 2'd0 && s.wa == 5'd0);
        if (s.re) begin
          out1_m[k] = mdl_read(k, s.b1, s.a1, s, wvalid, wbe);
          out2_m[k] = mdl_read(k, s.b2, s.a2, s, wvalid, wbe);
        end
        if (wvalid) mem_m[k][wbe][s.wa] = s.wd;
      end
    end
  endtask

  // Drive one cycle of stimulus to all three instances, clock it, and compare with the model.
  task automatic step(input stim_t s);
    logic [31:0] r1 [3];
    logic [31:0] r2 [3];
    logic        rv [3];
    logic        rdy [3];
    rst = s.rst;
    if_a.we = s.we; if_a.wd_bank = s.wb[0]; if_a.wd_addr = s.wa; if_a.wd_data = s.wd;
    if_a.rd_en = s.re; if_a.rs1_bank = s.b1[0]; if_a.rs1_addr = s.a1;
    if_a.rs2_bank = s.b2[0]; if_a.rs2_addr = s.a2;
    if_b.we = s.we; if_b.wd_bank = s.wb[0]; if_b.wd_addr = s.wa; if_b.wd_data = s.wd;
    if_b.rd_en = s.re; if_b.rs1_bank = s.b1[0]; if_b.rs1_addr = s.a1;
    if_b.rs2_bank = s.b2[0]; if_b.rs2_addr = s.a2;
    if_c.we = s.we; if_c.wd_bank = s.wb; if_c.wd_addr = s.wa; if_c.wd_data = s.wd;
    if_c.rd_en = s.re; if_c.rs1_bank = s.b1; if_c.rs1_addr = s.a1;
    if_c.rs2_bank = s.b2; if_c.rs2_addr = s.a2;
    @(posedge clk);
    model_edge(s);
    #1;
    r1[0] = if_a.rs1_data; r2[0] = if_a.rs2_data; rv[0] = if_a.rd_valid; rdy[0] = if_a.ready;
    r1[1] = if_b.rs1_data; r2[1] = if_b.rs2_data; rv[1] = if_b.rd_valid; rdy[1] = if_b.ready;
    r1[2] = if_c.rs1_data; r2[2] = if_c.rs2_data; rv[2] = if_c.rd_valid; rdy[2] = if_c.ready;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model.ready[%0d]", k), 32'(rdy[k]), 32'(ready_m));
      check($sformatf("model.rd_valid[%0d]", k), 32'(rv[k]), 32'(valid_m));
      check($sformatf("model.rs1[%0d]", k), r1[k], out1_m[k]);
      check($sformatf("model.rs2[%0d]", k), r2[k], out2_m[k]);
    end
  endtask

  // Release reset and expect ready to rise on exactly the 32nd edge.
  task automatic clear_and_check(input string tag);
    for (int c = 1; c <= 32; c++) begin
      step(idle_s());
      check($sformatf("%s.ready@%0d", tag, c), 32'(if_a.ready), (c == 32) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    stim_t s;
    ready_m = 1'b0; clr_m = 0; valid_m = 1'b0;
    for (int k = 0; k < 3; k++) begin out1_m[k] = 32'd0; out2_m[k] = 32'd0; end

    // Reset held 3 cycles, then the clear sequence.
    for (int i = 0; i < 3; i++) step(rst_s());
    clear_and_check("reset");

    // Directed vectors: expected outputs for configs A (bypass), B (no bypass), C (3 banks).
    add_vec(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd0, 5'd7, 2'd1, 5'd7), 1'b1,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    add_vec(idle_s(), 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    add_vec(mk(1'b1, 2'd0, 5'd0, 32'hDEADBEEF, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0), 1'b0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    add_vec(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd0, 5'd0, 2'd0, 5'd0), 1'b1,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    add_vec(mk(1'b1, 2'd1, 5'd0, 32'h3F800000, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0), 1'b0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    add_vec(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd1, 5'd0, 2'd1, 5'd0), 1'b1,
            32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    add_vec(mk(1'b1, 2'd0, 5'd5, 32'h12345678, 1'b1, 2'd0, 5'd5, 2'd0, 5'd5), 1'b1,
            32'h12345678, 32'h0, 32'h12345678, 32'h12345678, 32'h0, 32'h12345678);
    add_vec(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd0, 5'd5, 2'd0, 5'd5), 1'b1,
            32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
    add_vec(mk(1'b1, 2'd0, 5'd3, 32'hAAAA5555, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0), 1'b0,
            32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
    add_vec(mk(1'b1, 2'd1, 5'd3, 32'h0F0F0F0F, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0), 1'b0,
            32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
    add_vec(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd0, 5'd3, 2'd1, 5'd3), 1'b1,
            32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F);
    add_vec(mk(1'b1, 2'd3, 5'd4, 32'h11111111, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0), 1'b0,
            32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F);
    add_vec(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd3, 5'd4, 2'd3, 5'd4), 1'b1,
            32'h11111111, 32'h11111111, 32'h0, 32'h11111111, 32'h11111111, 32'h0);
    add_vec(mk(1'b1, 2'd2, 5'd4, 32'h11111111, 1'b0, 2'd0, 5'd0, 2'd0, 5'd0), 1'b0,
            32'h11111111, 32'h11111111, 32'h0, 32'h11111111, 32'h11111111, 32'h0);
    add_vec(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd2, 5'd4, 2'd2, 5'd4), 1'b1,
            32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111);
    add_vec(idle_s(), 1'b0,
            32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111);
    add_vec(mk(1'b1, 2'd0, 5'd0, 32'h00000055, 1'b1, 2'd0, 5'd0, 2'd0, 5'd0), 1'b1,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s);
      check($sformatf("vec%0d.valid", i), 32'(if_a.rd_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d.A.rs1", i), if_a.rs1_data, tbl[i].e1[0]);
      check($sformatf("vec%0d.A.rs2", i), if_a.rs2_data, tbl[i].e2[0]);
      check($sformatf("vec%0d.B.rs1", i), if_b.rs1_data, tbl[i].e1[1]);
      check($sformatf("vec%0d.B.rs2", i), if_b.rs2_data, tbl[i].e2[1]);
      check($sformatf("vec%0d.C.rs1", i), if_c.rs1_data, tbl[i].e1[2]);
      check($sformatf("vec%0d.C.rs2", i), if_c.rs2_data, tbl[i].e2[2]);
    end

    // Reset mid-clear: writes and reads during CLEAR are ignored; clear restarts from 0.
    step(rst_s());
    for (int i = 0; i < 10; i++)
      step(mk(1'b1, 2'd0, 5'd9, 32'hCAFEF00D, 1'b1, 2'd0, 5'd9, 2'd0, 5'd9));
    check("midclear.valid", 32'(if_a.rd_valid), 32'd0);
    step(rst_s());
    clear_and_check("midclear");
    step(mk(1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 2'd0, 5'd9, 2'd0, 5'd9));
    check("midclear.x9.A", if_a.rs1_data, 32'h0);
    check("midclear.x9.C", if_c.rs2_data, 32'h0);
    check("midclear.x9.valid", 32'(if_c.rd_valid), 32'd1);

    // Randomised traffic over a small address window to provoke collisions and bypasses.
    for (int i = 0; i < 600; i++) begin
      s = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
             $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
      s.rst = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      step(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
